// File: rtl/level_screen_ctrl_pkg.sv
// Shared screen codes and FSM state type for the game-screen sequencer.
// The SCR_* codes are the ones vga_bitchange decodes to pick a glyph set.
package level_screen_ctrl_pkg;

  localparam logic [2:0] SCR_TITLE      = 3'd0;
  localparam logic [2:0] SCR_PLAY       = 3'd1;
  localparam logic [2:0] SCR_LEVEL_DONE = 3'd2;
  localparam logic [2:0] SCR_GAME_OVER  = 3'd3;
  localparam logic [2:0] SCR_WIN        = 3'd4;

  typedef enum logic [2:0] {
    ST_TITLE      = 3'd0,
    ST_PLAYING    = 3'd1,
    ST_LEVEL_DONE = 3'd2,
    ST_GAME_OVER  = 3'd3,
    ST_WIN        = 3'd4
  } state_e;

  // Screen code shown while the FSM sits in a given state.
  function automatic logic [2:0] screen_code(state_e s);
    case (s)
      ST_PLAYING:    return SCR_PLAY;
      ST_LEVEL_DONE: return SCR_LEVEL_DONE;
      ST_GAME_OVER:  return SCR_GAME_OVER;
      ST_WIN:        return SCR_WIN;
      default:       return SCR_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-clk frame tick at the start of each VGA frame. The sync counters dwell
// at (0,0) for several clks, so the origin condition is edge-detected.
module frame_tick_gen (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       frame_tick
);

  logic at_origin;
  logic at_origin_d, at_origin_q;

  // Origin detect and delayed copy for the edge compare.
  always_comb begin
    at_origin   = (hCount == 10'd0) && (vCount == 10'd0);
    at_origin_d = at_origin;
    frame_tick  = at_origin && !at_origin_q;
  end

  // Previous-clk origin flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) at_origin_q <= 1'b0;
    else          at_origin_q <= at_origin_d;
  end

endmodule

// File: rtl/level_screen_ctrl.sv
// Game-screen sequencer: screen state, level number, banner timing, text blink.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_TITLE      | title screen, text blinks, wait for start press
// ST_PLAYING    | game running, overlay text off
// ST_LEVEL_DONE | "Level N Completed!" banner held for BANNER_FRAMES frames
// ST_GAME_OVER  | game over screen, text blinks, start returns to title
// ST_WIN        | final level cleared, start returns to title
module level_screen_ctrl
  import level_screen_ctrl_pkg::*;
#(
  parameter int BANNER_FRAMES = 120,
  parameter int BLINK_FRAMES  = 30,
  parameter int MAX_LEVEL     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       start_btn,
  input  logic       level_done,
  input  logic       player_dead,
  output logic [2:0] screen_sel,
  output logic       text_en,
  output logic [3:0] level_num,
  output logic       game_run,
  output logic       level_start
);

  localparam int FW = $clog2(BANNER_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BANNER_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    LVL_MAX    = 4'(MAX_LEVEL);

  logic frame_tick;
  logic start_rise;

  state_e        state_d, state_q;
  logic [3:0]    level_d, level_q;
  logic [FW-1:0] frame_cnt_d, frame_cnt_q;
  logic [BW-1:0] blink_cnt_d, blink_cnt_q;
  logic          text_en_d, text_en_q;
  logic [2:0]    screen_sel_d, screen_sel_q;
  logic          game_run_d, game_run_q;
  logic          level_start_d, level_start_q;
  logic          start_d, start_q;

  frame_tick_gen u_frame_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .hCount     (hCount),
    .vCount     (vCount),
    .frame_tick (frame_tick)
  );

  // Next state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    text_en_d   = text_en_q;
    start_d     = start_btn;
    start_rise  = start_btn && !start_q;

    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          state_d = ST_PLAYING;
          level_d = 4'd1;
        end
      end
      ST_PLAYING: begin
        // A death in the same clk as a clear still ends the game.
        if (player_dead)     state_d = ST_GAME_OVER;
        else if (level_done) state_d = ST_LEVEL_DONE;
      end
      ST_LEVEL_DONE: begin
        if (frame_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            if (level_q >= LVL_MAX) begin
              state_d = ST_WIN;
            end else begin
              state_d = ST_PLAYING;
              level_d = level_q + 4'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      ST_GAME_OVER, ST_WIN: begin
        if (start_rise) begin
          state_d = ST_TITLE;
          level_d = 4'd1;
        end
      end
      default: state_d = ST_TITLE;
    endcase

    if (state_d != state_q) begin
      // Entry into any state restarts its timing; text shows except in play.
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      text_en_d   = (state_d != ST_PLAYING);
    end else if ((state_q == ST_TITLE || state_q == ST_GAME_OVER) && frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        text_en_d   = !text_en_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    screen_sel_d  = screen_code(state_d);
    game_run_d    = (state_d == ST_PLAYING);
    level_start_d = (state_d == ST_PLAYING) && (state_q != ST_PLAYING);
  end

  // State and output registers; reset drops straight back to the title screen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_TITLE;
      level_q       <= 4'd1;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      text_en_q     <= 1'b1;
      screen_sel_q  <= SCR_TITLE;
      game_run_q    <= 1'b0;
      level_start_q <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      text_en_q     <= text_en_d;
      screen_sel_q  <= screen_sel_d;
      game_run_q    <= game_run_d;
      level_start_q <= level_start_d;
      start_q       <= start_d;
    end
  end

  assign screen_sel  = screen_sel_q;
  assign text_en     = text_en_q;
  assign level_num   = level_q;
  assign game_run    = game_run_q;
  assign level_start = level_start_q;

endmodule

// File: tb/tb_level_screen_ctrl.sv
// Directed + randomized bench for level_screen_ctrl with a screen-level model.
module tb_level_screen_ctrl;

  localparam int BANNER = 3;
  localparam int BLINK  = 2;
  localparam int MAXL   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hCount, vCount;
  logic       start_btn, level_done, player_dead;
  logic [2:0] screen_sel;
  logic       text_en;
  logic [3:0] level_num;
  logic       game_run;
  logic       level_start;

  int errors = 0;
  int checks = 0;
  int ls_cnt = 0;

  level_screen_ctrl #(
    .BANNER_FRAMES (BANNER),
    .BLINK_FRAMES  (BLINK),
    .MAX_LEVEL     (MAXL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hCount      (hCount),
    .vCount      (vCount),
    .start_btn   (start_btn),
    .level_done  (level_done),
    .player_dead (player_dead),
    .screen_sel  (screen_sel),
    .text_en     (text_en),
    .level_num   (level_num),
    .game_run    (game_run),
    .level_start (level_start)
  );

  always #5 clk = ~clk;

  // Reference model: screen mode (0..4 = screen code), level, and the number
  // of frame ticks seen since the current screen was entered.
  int m_mode, m_lvl, m_ticks;
  bit m_prev_org, m_prev_start, m_lstart;

  always @(posedge clk or negedge reset_n) begin
    bit tick, rise;
    int nm;
    if (!reset_n) begin
      m_mode = 0; m_lvl = 1; m_ticks = 0;
      m_prev_org = 0; m_prev_start = 0; m_lstart = 0;
    end else begin
      tick = (hCount == 10'd0 && vCount == 10'd0) && !m_prev_org;
      rise = start_btn && !m_prev_start;
      m_prev_org   = (hCount == 10'd0 && vCount == 10'd0);
      m_prev_start = start_btn;
      nm = m_mode;
      m_lstart = 0;
      case (m_mode)
        0: if (rise) begin nm = 1; m_lvl = 1; end
        1: if (player_dead) nm = 3; else if (level_done) nm = 2;
        2: if (tick && (m_ticks + 1 == BANNER)) begin
             if (m_lvl == MAXL) nm = 4;
             else begin nm = 1; m_lvl = m_lvl + 1; end
           end
        default: if (rise) begin nm = 0; m_lvl = 1; end
      endcase
      if (nm != m_mode) begin
        m_ticks = 0;
        if (nm == 1) m_lstart = 1;
      end else if (tick) begin
        m_ticks = m_ticks + 1;
      end
      m_mode = nm;
    end
  end

  function automatic bit exp_text();
    if (m_mode == 0 || m_mode == 3) return ((m_ticks / BLINK) % 2) == 0;
    if (m_mode == 1) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) if (level_start === 1'b1) ls_cnt++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".screen_sel"},  32'(screen_sel),  32'(m_mode));
    check({tag, ".text_en"},     32'(text_en),     32'(exp_text()));
    check({tag, ".level_num"},   32'(level_num),   32'(m_lvl));
    check({tag, ".game_run"},    32'(game_run),    32'(m_mode == 1));
    check({tag, ".level_start"}, 32'(level_start), 32'(m_lstart));
  endtask

  task automatic send_frame();
    int d;
    d = $urandom_range(2, 6);
    hCount = 10'($urandom_range(1, 799));
    vCount = 10'($urandom_range(0, 524));
    repeat (d) @(negedge clk);
    hCount = 10'd0;
    vCount = 10'd0;
    repeat (3) @(negedge clk);
    hCount = 10'd1;
    @(negedge clk);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input bit ld, input bit pd);
    level_done  = ld;
    player_dead = pd;
    @(negedge clk);
    level_done  = 1'b0;
    player_dead = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit exp_te;
    reset_n = 1'b0; hCount = 10'd5; vCount = 10'd5;
    start_btn = 1'b0; level_done = 1'b0; player_dead = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.screen_sel", 32'(screen_sel), 32'd0);
    check("reset.text_en", 32'(text_en), 32'd1);
    check("reset.level_num", 32'(level_num), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: title blink over 5 ticks
    exp_te = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_frame();
      if (i % 2 == 0) exp_te = !exp_te;
      check("title.text_en", 32'(text_en), 32'(exp_te));
      check_model("title");
    end
    check("title.game_run", 32'(game_run), 32'd0);

    // 2: held start gives one level_start
    ls_cnt = 0;
    start_btn = 1'b1;
    repeat (50) @(negedge clk);
    check("start.pulses", 32'(ls_cnt), 32'd1);
    check("start.screen_sel", 32'(screen_sel), 32'd1);
    check("start.text_en", 32'(text_en), 32'd0);
    check_model("start");
    start_btn = 1'b0;
    @(negedge clk);

    // 3: banner for level 1 with ignored presses
    pulse(1'b1, 1'b0);
    check("banner1.screen_sel", 32'(screen_sel), 32'd2);
    ls_cnt = 0;
    for (int i = 0; i < BANNER; i++) begin
      if (i < BANNER - 1) begin
        press_start();
        check("banner1.hold", 32'(screen_sel), 32'd2);
      end
      send_frame();
      check_model("banner1");
    end
    check("banner1.exit_sel", 32'(screen_sel), 32'd1);
    check("banner1.level", 32'(level_num), 32'd2);
    check("banner1.pulses", 32'(ls_cnt), 32'd1);

    // 4: last level -> WIN -> TITLE
    pulse(1'b1, 1'b0);
    repeat (BANNER) send_frame();
    check("win.screen_sel", 32'(screen_sel), 32'd4);
    check("win.text_en", 32'(text_en), 32'd1);
    check("win.level", 32'(level_num), 32'd2);
    press_start();
    check("win2title.screen_sel", 32'(screen_sel), 32'd0);
    check("win2title.level", 32'(level_num), 32'd1);
    check_model("win2title");

    // 5: simultaneous clear and death
    press_start();
    pulse(1'b1, 1'b1);
    check("dead.screen_sel", 32'(screen_sel), 32'd3);
    check("dead.game_run", 32'(game_run), 32'd0);
    check("dead.text_en", 32'(text_en), 32'd1);
    repeat (2) send_frame();
    check("dead.blink", 32'(text_en), 32'd0);
    check_model("dead");
    press_start();
    check_model("dead2title");

    // 6: async reset mid-banner, then full banner afterwards
    press_start();
    pulse(1'b1, 1'b0);
    send_frame();
    check("midbanner.screen_sel", 32'(screen_sel), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async.screen_sel", 32'(screen_sel), 32'd0);
    check("async.text_en", 32'(text_en), 32'd1);
    check("async.level_num", 32'(level_num), 32'd1);
    check("async.game_run", 32'(game_run), 32'd0);
    check("async.level_start", 32'(level_start), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    press_start();
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= BANNER; i++) begin
      send_frame();
      check("rebanner.screen_sel", 32'(screen_sel), (i < BANNER) ? 32'd2 : 32'd1);
      check_model("rebanner");
    end

    // Random actions checked against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: send_frame();
        1: press_start();
        2: pulse(1'b1, 1'b0);
        3: pulse(1'b0, ($urandom_range(0, 3) == 0));
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
      check_model("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
